// File: rtl/driver_fifo_if.sv
// ---------------------------------------------------------------------------
// driver_fifo_if -- control/status bundle between a UART echo driver and its
// environment.
//   br_cfg    : baud divisor select (environment -> driver)
//   rda       : UART holds a received byte (environment -> driver)
//   tbr       : UART transmit buffer ready (environment -> driver)
//   iocs      : UART chip select (driver -> environment)
//   iorw      : 1 = read, 0 = write (driver -> environment)
//   ioaddr    : 00 data, 10 divisor low, 11 divisor high (driver -> environment)
//   fifo_cnt  : echo FIFO occupancy (driver -> environment)
//   cfg_done  : divisor programmed and driver running (driver -> environment)
//   fifo_full : fifo_cnt equals DEPTH (driver -> environment)
// The shared databus is not part of this bundle; it is a plain inout port on
// the driver so that it resolves like a board-level net.
// ---------------------------------------------------------------------------
interface driver_fifo_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [1:0]       br_cfg;
   logic             rda;
   logic             tbr;
   logic             iocs;
   logic             iorw;
   logic [1:0]       ioaddr;
   logic [CNT_W-1:0] fifo_cnt;
   logic             cfg_done;
   logic             fifo_full;

   modport slave (
      input  br_cfg, rda, tbr,
      output iocs, iorw, ioaddr, fifo_cnt, cfg_done, fifo_full
   );

   modport master (
      output br_cfg, rda, tbr,
      input  iocs, iorw, ioaddr, fifo_cnt, cfg_done, fifo_full
   );
endinterface

// File: rtl/driver_fifo.sv
// ---------------------------------------------------------------------------
// driver_fifo -- programs a UART baud divisor, then echoes every received
// byte back through a small FIFO.
//   clk     : single clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : driver_fifo_if.slave (br_cfg, rda, tbr in; iocs, iorw, ioaddr,
//             fifo_cnt, cfg_done, fifo_full out)
//   databus : shared DATA_W-bit bus, driven only for writes (iocs=1, iorw=0)
// Priority in RUN: reconfigure > write (drain FIFO) > read (fill FIFO).
// A full FIFO simply stops reading, so bytes wait in the UART; nothing drops.
// ---------------------------------------------------------------------------
module driver_fifo #(
   parameter int          DATA_W = 8,
   parameter int          DEPTH  = 4,
   parameter logic [15:0] DIV0   = 16'h0515,
   parameter logic [15:0] DIV1   = 16'h028A,
   parameter logic [15:0] DIV2   = 16'h0145,
   parameter logic [15:0] DIV3   = 16'h00A2
) (
   input  logic              clk,
   input  logic              rst,
   driver_fifo_if.slave      bus,
   inout  wire  [DATA_W-1:0] databus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [2:0] {CFG_LO, CFG_HI, RUN, RD_REQ, RD_CAP, WR} state_t;

   state_t           state_q, state_d;
   logic [1:0]       brcfg_q, brcfg_d;
   logic             need_cfg_q, need_cfg_d;
   logic             cfg_done_q, cfg_done_d;
   logic             iocs_q, iocs_d;
   logic             iorw_q, iorw_d;
   logic [1:0]       ioaddr_q, ioaddr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full_q, full_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             push, pop;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] dbus_q;

   logic [1:0]  div_idx;
   logic [15:0] div_word;
   logic [7:0]  cfg_byte;

   function automatic logic [15:0] div_sel(input logic [1:0] sel);
      case (sel)
         2'd0:    div_sel = DIV0;
         2'd1:    div_sel = DIV1;
         2'd2:    div_sel = DIV2;
         default: div_sel = DIV3;
      endcase
   endfunction

   // Entering CFG_LO uses the live br_cfg (the value being registered);
   // CFG_HI uses the copy captured on that entry.
   assign div_idx  = (state_q == RUN) ? bus.br_cfg : brcfg_q;
   assign div_word = div_sel(div_idx);
   assign cfg_byte = (state_d == CFG_LO) ? div_word[7:0] : div_word[15:8];

   // ---------------- next-state and registered-output logic ----------------
   always_comb begin
      state_d    = state_q;
      brcfg_d    = brcfg_q;
      need_cfg_d = need_cfg_q;
      cfg_done_d = cfg_done_q;
      iocs_d     = 1'b0;
      iorw_d     = 1'b0;
      ioaddr_d   = 2'b00;
      push       = 1'b0;
      pop        = 1'b0;

      case (state_q)
         RUN: begin
            // need_cfg_q forces the first configuration after reset
            if (need_cfg_q || (bus.br_cfg != brcfg_q)) begin
               state_d    = CFG_LO;
               brcfg_d    = bus.br_cfg;
               need_cfg_d = 1'b0;
               cfg_done_d = 1'b0;
               iocs_d     = 1'b1;
               ioaddr_d   = 2'b10;
            end else if (bus.tbr && (cnt_q != '0)) begin
               state_d = WR;
               iocs_d  = 1'b1;
            end else if (bus.rda && !full_q) begin
               state_d = RD_REQ;
               iocs_d  = 1'b1;
               iorw_d  = 1'b1;
            end
         end
         CFG_LO: begin
            state_d  = CFG_HI;
            iocs_d   = 1'b1;
            ioaddr_d = 2'b11;
         end
         CFG_HI: begin
            state_d    = RUN;
            cfg_done_d = 1'b1;
         end
         RD_REQ: begin
            state_d = RD_CAP;
            iocs_d  = 1'b1;
            iorw_d  = 1'b1;
         end
         RD_CAP: begin
            state_d = RUN;
            push    = 1'b1;
         end
         WR: begin
            state_d = RUN;
            pop     = 1'b1;
         end
         default: state_d = RUN;
      endcase

      cnt_d    = cnt_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         cnt_d    = cnt_q + CNT_W'(1);
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else if (pop) begin
         cnt_d    = cnt_q - CNT_W'(1);
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      full_d = (cnt_d == CNT_W'(DEPTH));
   end

   // Reset comes out through RUN with need_cfg set, so the cycle after the
   // first non-reset edge is already CFG_LO with its outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         brcfg_q    <= 2'b00;
         need_cfg_q <= 1'b1;
         cfg_done_q <= 1'b0;
         iocs_q     <= 1'b0;
         iorw_q     <= 1'b0;
         ioaddr_q   <= 2'b00;
         cnt_q      <= '0;
         full_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         brcfg_q    <= brcfg_d;
         need_cfg_q <= need_cfg_d;
         cfg_done_q <= cfg_done_d;
         iocs_q     <= iocs_d;
         iorw_q     <= iorw_d;
         ioaddr_q   <= ioaddr_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // FIFO storage and the outgoing data register. A push under reset lands
   // in storage but the pointers/count reset, so the byte is discarded.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= databus;
      end
      case (state_d)
         CFG_LO, CFG_HI: dbus_q <= DATA_W'(cfg_byte);
         WR:             dbus_q <= mem[rd_ptr_q];
         default:        ;
      endcase
   end

   assign databus = (iocs_q && !iorw_q) ? dbus_q : {DATA_W{1'bz}};

   assign bus.iocs      = iocs_q;
   assign bus.iorw      = iorw_q;
   assign bus.ioaddr    = ioaddr_q;
   assign bus.fifo_cnt  = cnt_q;
   assign bus.cfg_done  = cfg_done_q;
   assign bus.fifo_full = full_q;
endmodule

// File: tb/tb_driver_fifo.sv
// ---------------------------------------------------------------------------
// tb_driver_fifo -- self-checking bench for driver_fifo (DEPTH=4, DATA_W=8).
// A UART model holds received bytes in an array; the monitor logs every bus
// write and every completed read. Each test task drives stimulus and compares
// against expectations derived from the requirements.
// ---------------------------------------------------------------------------
module tb_driver_fifo;
   logic clk;
   logic rst;
   wire  [7:0] databus;

   driver_fifo_if #(.DEPTH(4)) bus ();

   driver_fifo #(.DATA_W(8), .DEPTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .databus (databus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] addr;
      logic [7:0] data;
      int         cyc;
   } wr_t;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // UART receive side model
   logic [7:0] rx_mem [1024];
   int   rx_pushed = 0;   // written by tasks only
   int   rx_popped = 0;   // written by monitor only
   logic [7:0] rx_hold = 8'h00;
   logic rd_first = 1'b0;
   logic in_cap   = 1'b0;
   int   rd_done  = 0;
   int   echo_cnt = 0;
   int   lost     = 0;

   wr_t        wr_log[$];
   logic [7:0] echo_log[$];

   assign bus.rda = (rx_pushed != rx_popped);
   assign databus = (bus.iocs && bus.iorw) ? rx_hold : 8'hzz;

   function automatic logic [15:0] div_of(input logic [1:0] sel);
      case (sel)
         2'd0:    div_of = 16'h0515;
         2'd1:    div_of = 16'h028A;
         2'd2:    div_of = 16'h0145;
         default: div_of = 16'h00A2;
      endcase
   endfunction

   function automatic int exp_cnt();
      exp_cnt = rd_done - echo_cnt - lost;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      in_cap = 1'b0;
      if (bus.iocs && bus.iorw) begin
         if (!rd_first) begin
            rd_first = 1'b1;
            rx_hold  = rx_mem[rx_popped % 1024];
         end else begin
            rd_first = 1'b0;
            in_cap   = 1'b1;
            rd_done++;
            rx_popped++;
            $display("bus read  data=%h cyc=%0d", rx_hold, cyc);
         end
      end else begin
         rd_first = 1'b0;
      end
      if (bus.iocs && !bus.iorw) begin
         wr_log.push_back('{addr: bus.ioaddr, data: databus, cyc: cyc});
         $display("bus write addr=%b data=%h cyc=%0d", bus.ioaddr, databus, cyc);
         if (bus.ioaddr == 2'b00) begin
            echo_log.push_back(databus);
            echo_cnt++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic uart_rx(input logic [7:0] b);
      rx_mem[rx_pushed % 1024] = b;
      rx_pushed++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.br_cfg = 2'b01;
      bus.tbr = 1'b0;
      step(3);
      checks++; if (bus.iocs !== 1'b0) begin errors++; $display("FAIL reset_iocs got=%b exp=0", bus.iocs); end
      checks++; if (bus.iorw !== 1'b0) begin errors++; $display("FAIL reset_iorw got=%b exp=0", bus.iorw); end
      checks++; if (bus.ioaddr !== 2'b00) begin errors++; $display("FAIL reset_ioaddr got=%b exp=00", bus.ioaddr); end
      checks++; if (bus.cfg_done !== 1'b0) begin errors++; $display("FAIL reset_cfg_done got=%b exp=0", bus.cfg_done); end
      checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL reset_fifo_cnt got=%0d exp=0", bus.fifo_cnt); end
      checks++; if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got=%b exp=0", bus.fifo_full); end
      $display("test_reset done");
   endtask

   // Checks a configuration pair starting at log index b
   task automatic check_cfg(input string nm, input int b, input logic [1:0] sel, input int first_cyc);
      logic [15:0] d;
      d = div_of(sel);
      checks++;
      if (wr_log.size() < b + 2) begin
         errors++;
         $display("FAIL %s_count got=%0d exp=2", nm, wr_log.size() - b);
      end else begin
         if (wr_log[b].addr !== 2'b10 || wr_log[b].data !== d[7:0]) begin
            errors++;
            $display("FAIL %s_lo got=%b/%h exp=10/%h", nm, wr_log[b].addr, wr_log[b].data, d[7:0]);
         end
         checks++;
         if (wr_log[b+1].addr !== 2'b11 || wr_log[b+1].data !== d[15:8]) begin
            errors++;
            $display("FAIL %s_hi got=%b/%h exp=11/%h", nm, wr_log[b+1].addr, wr_log[b+1].data, d[15:8]);
         end
         checks++;
         if (wr_log[b].cyc != first_cyc || wr_log[b+1].cyc != first_cyc + 1) begin
            errors++;
            $display("FAIL %s_timing got=%0d,%0d exp=%0d,%0d", nm, wr_log[b].cyc, wr_log[b+1].cyc, first_cyc, first_cyc + 1);
         end
      end
      checks++;
      if (bus.cfg_done !== 1'b1) begin errors++; $display("FAIL %s_cfg_done got=%b exp=1", nm, bus.cfg_done); end
   endtask

   task automatic test_config();
      int b, k;
      b = wr_log.size();
      k = cyc;
      rst = 1'b0;
      step(4);
      check_cfg("config", b, 2'b01, k + 1);
      $display("test_config done");
   endtask

   task automatic check_echo(input string nm, input int b, input logic [7:0] exp_q[$]);
      checks++;
      if (echo_log.size() - b != exp_q.size()) begin
         errors++;
         $display("FAIL %s_echo_count got=%0d exp=%0d", nm, echo_log.size() - b, exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (echo_log[b+i] !== exp_q[i]) begin
               errors++;
               $display("FAIL %s_echo[%0d] got=%h exp=%h", nm, i, echo_log[b+i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_echo();
      logic [7:0] exp_q[$];
      int b;
      b = echo_log.size();
      exp_q = '{8'h41, 8'h42, 8'h43};
      bus.tbr = 1'b0;
      foreach (exp_q[i]) uart_rx(exp_q[i]);
      step(20);
      checks++; if (bus.fifo_cnt !== 3'd3) begin errors++; $display("FAIL echo_fill got=%0d exp=3", bus.fifo_cnt); end
      checks++; if (echo_log.size() != b) begin errors++; $display("FAIL echo_early got=%0d exp=0", echo_log.size() - b); end
      bus.tbr = 1'b1;
      step(20);
      check_echo("echo", b, exp_q);
      checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL echo_drain got=%0d exp=0", bus.fifo_cnt); end
      bus.tbr = 1'b0;
      $display("test_echo done");
   endtask

   task automatic test_full();
      logic [7:0] exp_q[$];
      int b;
      b = echo_log.size();
      for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom_range(0, 255)));
      foreach (exp_q[i]) uart_rx(exp_q[i]);
      step(40);
      checks++; if (bus.fifo_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got=%0d exp=4", bus.fifo_cnt); end
      checks++; if (bus.fifo_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", bus.fifo_full); end
      checks++; if (rx_pushed - rx_popped != 2) begin errors++; $display("FAIL full_pending got=%0d exp=2", rx_pushed - rx_popped); end
      bus.tbr = 1'b1;
      step(60);
      check_echo("full", b, exp_q);
      checks++; if (bus.fifo_full !== 1'b0 || bus.fifo_cnt !== 3'd0) begin
         errors++; $display("FAIL full_drain got=%0d/%b exp=0/0", bus.fifo_cnt, bus.fifo_full);
      end
      bus.tbr = 1'b0;
      $display("test_full done");
   endtask

   task automatic test_priority();
      logic [7:0] exp_q[$];
      int b;
      b = echo_log.size();
      exp_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      uart_rx(exp_q[0]);
      step(10);
      checks++; if (bus.fifo_cnt !== 3'd1) begin errors++; $display("FAIL prio_setup got=%0d exp=1", bus.fifo_cnt); end
      bus.tbr = 1'b1;
      uart_rx(exp_q[1]);
      step(1);
      checks++;
      if (bus.iocs !== 1'b1 || bus.iorw !== 1'b0 || bus.ioaddr !== 2'b00 || databus !== exp_q[0]) begin
         errors++;
         $display("FAIL prio_wr_first got=%b%b%b/%h exp=1000/%h", bus.iocs, bus.iorw, bus.ioaddr, databus, exp_q[0]);
      end
      step(1);
      checks++; if (bus.iocs !== 1'b0) begin errors++; $display("FAIL prio_run got=%b exp=0", bus.iocs); end
      step(1);
      checks++; if (bus.iocs !== 1'b1 || bus.iorw !== 1'b1) begin
         errors++; $display("FAIL prio_rd_next got=%b%b exp=11", bus.iocs, bus.iorw);
      end
      step(12);
      check_echo("prio", b, exp_q);
      bus.tbr = 1'b0;
      $display("test_priority done");
   endtask

   task automatic test_reconfig();
      logic [7:0] exp_q[$];
      int b, wb, k;
      bus.br_cfg = 2'b00;
      step(6);
      b = echo_log.size();
      exp_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      foreach (exp_q[i]) uart_rx(exp_q[i]);
      step(12);
      checks++; if (bus.fifo_cnt !== 3'd2) begin errors++; $display("FAIL reconf_setup got=%0d exp=2", bus.fifo_cnt); end
      wb = wr_log.size();
      k = cyc;
      bus.br_cfg = 2'b11;
      step(4);
      check_cfg("reconf", wb, 2'b11, k + 1);
      checks++; if (bus.fifo_cnt !== 3'd2) begin errors++; $display("FAIL reconf_keep got=%0d exp=2", bus.fifo_cnt); end
      bus.tbr = 1'b1;
      step(10);
      check_echo("reconf", b, exp_q);
      bus.tbr = 1'b0;
      $display("test_reconfig done");
   endtask

   task automatic test_reset_mid();
      int wb, k;
      logic found;
      found = 1'b0;
      uart_rx(8'hC3);
      for (int i = 0; i < 20 && !found; i++) begin
         step(1);
         if (in_cap) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rstmid_wait got=timeout exp=read_capture");
      end
      lost += exp_cnt();
      rst = 1'b1;
      step(1);
      checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d exp=0", bus.fifo_cnt); end
      checks++; if (bus.iocs !== 1'b0) begin errors++; $display("FAIL rstmid_iocs got=%b exp=0", bus.iocs); end
      checks++; if (bus.cfg_done !== 1'b0) begin errors++; $display("FAIL rstmid_cfg_done got=%b exp=0", bus.cfg_done); end
      wb = wr_log.size();
      k = cyc;
      rst = 1'b0;
      step(4);
      check_cfg("rstmid", wb, bus.br_cfg, k + 1);
      checks++; if (int'(bus.fifo_cnt) != exp_cnt()) begin errors++; $display("FAIL rstmid_model got=%0d exp=%0d", bus.fifo_cnt, exp_cnt()); end
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] v;
      logic [15:0] w;
      int b, wb, last;
      b = echo_log.size();
      wb = wr_log.size();
      for (int i = 0; i < 300; i++) begin
         step(1);
         if ($urandom_range(0, 3) == 0 && exp_q.size() < 40) begin
            v = 8'($urandom_range(0, 255));
            exp_q.push_back(v);
            uart_rx(v);
         end
         bus.tbr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) bus.br_cfg = 2'($urandom_range(0, 3));
         checks++;
         if (int'(bus.fifo_cnt) > 4) begin errors++; $display("FAIL rand_bound got=%0d exp<=4", bus.fifo_cnt); end
      end
      bus.br_cfg = bus.br_cfg + 2'd1;
      bus.tbr = 1'b1;
      step(300);
      check_echo("rand", b, exp_q);
      checks++; if (bus.fifo_cnt !== 3'd0) begin errors++; $display("FAIL rand_drain got=%0d exp=0", bus.fifo_cnt); end
      last = -1;
      for (int i = wb; i < wr_log.size(); i++) begin
         if (wr_log[i].addr == 2'b10) begin
            checks++;
            if (i + 1 >= wr_log.size() || wr_log[i+1].addr !== 2'b11 || wr_log[i+1].cyc != wr_log[i].cyc + 1) begin
               errors++;
               $display("FAIL rand_cfg_pair got=unpaired exp=pair at cyc %0d", wr_log[i].cyc);
            end else begin
               w = {wr_log[i+1].data, wr_log[i].data};
               last = int'(w);
               checks++;
               if (w != div_of(2'd0) && w != div_of(2'd1) && w != div_of(2'd2) && w != div_of(2'd3)) begin
                  errors++;
                  $display("FAIL rand_cfg_word got=%h exp=table", w);
               end
            end
         end
      end
      w = div_of(bus.br_cfg);
      checks++;
      if (last != int'(w)) begin errors++; $display("FAIL rand_cfg_last got=%0h exp=%h", last, w); end
      bus.tbr = 1'b0;
      $display("test_random done");
   endtask

   initial begin
      rst = 1'b1;
      bus.br_cfg = 2'b01;
      bus.tbr = 1'b0;
      test_reset();
      test_config();
      test_echo();
      test_full();
      test_priority();
      test_reconfig();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
